// File: rtl/emmc_raid_cmd_fanout.sv
// RAID0 command fan-out: broadcasts one SD/eMMC command to NUM_DEV devices and merges their results.
// Optional build macro RESP_COMPARE_EN adds cross-device short-response comparison (RMM status bit).
module emmc_raid_cmd_fanout #(
    parameter int unsigned NUM_DEV  = 2,
    parameter int unsigned TO_W     = 10,
    parameter int unsigned TO_SHORT = 120,
    parameter int unsigned TO_LONG  = 250
) (
    input  logic                     sd_clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     int_status_rst_i,
    input  logic [5:0]               cmd_index_i,
    input  logic [31:0]              argument_i,
    input  logic [1:0]               resp_type_i,
    input  logic                     crc_check_i,
    input  logic                     index_check_i,
    input  logic [NUM_DEV-1:0]       finish_i,
    input  logic [NUM_DEV-1:0]       crc_ok_i,
    input  logic [NUM_DEV-1:0]       index_ok_i,
    input  logic [NUM_DEV-1:0]       busy_i,
    input  logic [120*NUM_DEV-1:0]   response_i,
    output logic [39:0]              cmd_o,
    output logic [1:0]               setting_o,
    output logic                     start_xfr_o,
    output logic                     go_idle_o,
    output logic [6:0]               int_status_o,
    output logic [NUM_DEV-1:0]       err_dev_o,
    output logic [31:0]              response_0_o,
    output logic [31:0]              response_1_o,
    output logic [31:0]              response_2_o,
    output logic [31:0]              response_3_o,
    output logic                     busy_o
);

    localparam int unsigned RESP_W = 120;

    typedef enum logic [1:0] {IDLE, EXECUTE, BUSY_CHECK} state_t;

    state_t              state, state_n;
    logic [39:0]         cmd_n;
    logic [1:0]          setting_n;
    logic                crc_chk, crc_chk_n;
    logic                idx_chk, idx_chk_n;
    logic                busy_cmd, busy_cmd_n;
    logic                limit_en, limit_en_n;
    logic [TO_W-1:0]     limit, limit_n;
    logic [TO_W-1:0]     watchdog, watchdog_n;
    logic [NUM_DEV-1:0]  done_mask, done_n;
    logic [NUM_DEV-1:0]  err_n;
    logic [NUM_DEV-1:0]  new_fin;
    logic [6:0]          status, status_n;
    logic [31:0]         r0_n, r1_n, r2_n, r3_n;
    logic                start_xfr_n, go_idle_n;
`ifdef RESP_COMPARE_EN
    logic [31:0]         cap [NUM_DEV];
    logic [31:0]         cap_n [NUM_DEV];
    logic [NUM_DEV-1:0]  pend, pend_n;
`endif

    // Only the top short-response word of each device is consumed in some builds.
    logic unused_resp;
    assign unused_resp = ^response_i;

    // Next-state, status merge and output computation.
    always_comb begin
        state_n     = state;
        cmd_n       = cmd_o;
        setting_n   = setting_o;
        crc_chk_n   = crc_chk;
        idx_chk_n   = idx_chk;
        busy_cmd_n  = busy_cmd;
        limit_en_n  = limit_en;
        limit_n     = limit;
        watchdog_n  = watchdog;
        done_n      = done_mask;
        err_n       = err_dev_o;
        status_n    = status;
        r0_n        = response_0_o;
        r1_n        = response_1_o;
        r2_n        = response_2_o;
        r3_n        = response_3_o;
        start_xfr_n = 1'b0;
        go_idle_n   = 1'b0;
        new_fin     = '0;
`ifdef RESP_COMPARE_EN
        cap_n       = cap;
        pend_n      = pend;
`endif
        case (state)
            IDLE: begin
                if (start_i) begin
                    cmd_n       = {2'b01, cmd_index_i, argument_i};
                    setting_n   = {resp_type_i == 2'b01, resp_type_i != 2'b00};
                    crc_chk_n   = crc_check_i;
                    idx_chk_n   = index_check_i;
                    busy_cmd_n  = (resp_type_i == 2'b11);
                    limit_en_n  = (resp_type_i != 2'b00);
                    limit_n     = (resp_type_i == 2'b01) ? TO_W'(TO_LONG) : TO_W'(TO_SHORT);
                    done_n      = '0;
                    err_n       = '0;
                    watchdog_n  = '0;
                    status_n    = '0;
`ifdef RESP_COMPARE_EN
                    pend_n      = '0;
`endif
                    start_xfr_n = 1'b1;
                    state_n     = EXECUTE;
                end
            end
            EXECUTE: begin
                new_fin = finish_i & ~done_mask;
                done_n  = done_mask | finish_i;
                if (watchdog != '1) begin
                    watchdog_n = watchdog + 1'b1;
                end
                for (int d = 0; d < int'(NUM_DEV); d++) begin
                    if (new_fin[d]) begin
                        if (crc_chk && !crc_ok_i[d]) begin
                            status_n[3] = 1'b1;
                            status_n[5] = 1'b1;
                            err_n[d]    = 1'b1;
                        end
                        if (idx_chk && !index_ok_i[d]) begin
                            status_n[4] = 1'b1;
                            status_n[5] = 1'b1;
                            err_n[d]    = 1'b1;
                        end
                    end
                end
                if (new_fin[0]) begin
                    if (setting_n[1]) begin
                        r3_n = {8'h00, response_i[119:96]};
                        r2_n = response_i[95:64];
                        r1_n = response_i[63:32];
                        r0_n = response_i[31:0];
                    end else if (setting_n[0]) begin
                        r0_n = response_i[119:88];
                    end
                end
`ifdef RESP_COMPARE_EN
                // Compare against device 0 as soon as its word is known; otherwise hold pending.
                for (int d = 0; d < int'(NUM_DEV); d++) begin
                    if (new_fin[d]) begin
                        cap_n[d] = response_i[RESP_W*d+88 +: 32];
                    end
                end
                for (int d = 1; d < int'(NUM_DEV); d++) begin
                    if (setting_o[0] && (new_fin[d] || pend[d])) begin
                        if (done_n[0]) begin
                            pend_n[d] = 1'b0;
                            if (cap_n[d] != cap_n[0]) begin
                                status_n[6] = 1'b1;
                                status_n[5] = 1'b1;
                                err_n[d]    = 1'b1;
                            end
                        end else begin
                            pend_n[d] = 1'b1;
                        end
                    end
                end
`endif
                if (&done_n) begin
                    if (busy_cmd) begin
                        state_n = BUSY_CHECK;
                    end else begin
                        status_n[0] = 1'b1;
                        state_n     = IDLE;
                    end
                end else if (limit_en && (watchdog >= limit)) begin
                    status_n[2] = 1'b1;
                    status_n[5] = 1'b1;
                    err_n       = err_n | ~done_n;
                    go_idle_n   = 1'b1;
                    state_n     = IDLE;
                end
            end
            BUSY_CHECK: begin
                if (busy_i == '0) begin
                    status_n[0] = 1'b1;
                    status_n[1] = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
`ifndef RESP_COMPARE_EN
        status_n[6] = 1'b0;
`endif
        if (int_status_rst_i) begin
            status_n = '0;
            err_n    = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cmd_o        <= '0;
            setting_o    <= '0;
            crc_chk      <= 1'b0;
            idx_chk      <= 1'b0;
            busy_cmd     <= 1'b0;
            limit_en     <= 1'b0;
            limit        <= '0;
            watchdog     <= '0;
            done_mask    <= '0;
            err_dev_o    <= '0;
            status       <= '0;
            int_status_o <= '0;
            response_0_o <= '0;
            response_1_o <= '0;
            response_2_o <= '0;
            response_3_o <= '0;
            start_xfr_o  <= 1'b0;
            go_idle_o    <= 1'b0;
            busy_o       <= 1'b0;
`ifdef RESP_COMPARE_EN
            cap          <= '{default: '0};
            pend         <= '0;
`endif
        end else begin
            state        <= state_n;
            cmd_o        <= cmd_n;
            setting_o    <= setting_n;
            crc_chk      <= crc_chk_n;
            idx_chk      <= idx_chk_n;
            busy_cmd     <= busy_cmd_n;
            limit_en     <= limit_en_n;
            limit        <= limit_n;
            watchdog     <= watchdog_n;
            done_mask    <= done_n;
            err_dev_o    <= err_n;
            status       <= status_n;
            int_status_o <= (state_n == IDLE) ? status_n : 7'd0;
            response_0_o <= r0_n;
            response_1_o <= r1_n;
            response_2_o <= r2_n;
            response_3_o <= r3_n;
            start_xfr_o  <= start_xfr_n;
            go_idle_o    <= go_idle_n;
            busy_o       <= (state_n != IDLE);
`ifdef RESP_COMPARE_EN
            cap          <= cap_n;
            pend         <= pend_n;
`endif
        end
    end

endmodule
